gray_cnt_arbiter: RTL and testbench

Round-robin arbiter that shares one free-running Gray-code counter among NREQ requesters. Each requester asks for a burst of counter steps. The arbiter grants one requester at a time, advances the shared binary/Gray counter once per cycle for the burst length, and pulses wrap whenever the Gray value returns to zero. It sits in front of the Gray counter datapath and replaces per-client counters with a single sequenced resource.

---
 rtl/gray_cnt_arbiter.sv | 119 +++++++++++
 tb/tb_gray_cnt_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_cnt_arbiter.sv
// Round-robin arbiter sharing one Gray-code counter among NREQ clients.
// Each grant runs a burst of counter steps; wrap pulses on return to zero.
module gray_cnt_arbiter #(
  parameter int CBITS = 8,
  parameter int NREQ  = 4,
  parameter int LENW  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*LENW-1:0] len,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic [CBITS-1:0]     gray_cnt,
  output logic                 wrap,
  output logic [NREQ-1:0]      done
);

  localparam int PTRW = $clog2(NREQ);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [CBITS-1:0] r_bin;
  logic [CBITS-1:0] r_gray;
  logic             r_wrap;
  logic [LENW-1:0]  r_rem;
  logic [PTRW-1:0]  r_ptr;
  logic [NREQ-1:0]  r_gnt;

  logic             w_hit;
  logic [PTRW-1:0]  w_win;
  logic [PTRW-1:0]  w_ptr_nx;
  logic [NREQ-1:0]  w_onehot;
  logic [LENW-1:0]  w_len;
  logic [LENW-1:0]  w_len_eff;
  logic [CBITS-1:0] w_bin_nx;
  logic             w_last;

  // First set request at or above ptr, wrapping modulo NREQ
  always_comb begin
    w_hit = 1'b0;
    w_win = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_hit && req[(int'(r_ptr) + i) % NREQ]) begin
        w_hit = 1'b1;
        w_win = PTRW'((int'(r_ptr) + i) % NREQ);
      end
    end
  end

  assign w_onehot  = NREQ'(1) << w_win;
  assign w_ptr_nx  = (w_win == PTRW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign w_len     = len[w_win*LENW +: LENW];
  assign w_len_eff = (w_len == '0) ? LENW'(1) : w_len;
  assign w_bin_nx  = r_bin + 1'b1;
  assign w_last    = (r_rem == LENW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (w_hit) w_state_nx = S_RUN;
      S_RUN:  if (w_last) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= '0;
      r_gray <= '0;
      r_wrap <= 1'b0;
      r_rem  <= '0;
      r_ptr  <= '0;
      r_gnt  <= '0;
    end else begin
      r_wrap <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_gnt <= w_onehot;
            r_rem <= w_len_eff;
            r_ptr <= w_ptr_nx;
          end
        end
        S_RUN: begin
          r_bin  <= w_bin_nx;
          r_gray <= w_bin_nx ^ (w_bin_nx >> 1);
          r_wrap <= (w_bin_nx == '0);
          r_rem  <= r_rem - 1'b1;
          if (w_last) r_gnt <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt      = r_gnt;
    busy     = |r_gnt;
    gray_cnt = r_gray;
    wrap     = r_wrap;
    done     = r_gnt & {NREQ{w_last}};
  end

endmodule

// File: tb/tb_gray_cnt_arbiter.sv
// Directed self-checking bench for gray_cnt_arbiter.
// Default parameters: CBITS=8, NREQ=4, LENW=4.
module tb_gray_cnt_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  gnt;
  logic        busy;
  logic [7:0]  gray_cnt;
  logic        wrap;
  logic [3:0]  done;

  int nchk;
  int nerr;

  gray_cnt_arbiter #(
    .CBITS(8),
    .NREQ (4),
    .LENW (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .len     (len),
    .gnt     (gnt),
    .busy    (busy),
    .gray_cnt(gray_cnt),
    .wrap    (wrap),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    @(negedge clk);
    @(negedge clk);
    nchk++;
    if ({gnt, busy, gray_cnt, wrap, done} !== 18'd0) begin
      nerr++;
      $display("FAIL reset_hold: gnt=%b busy=%b gray=%h wrap=%b done=%b",
               gnt, busy, gray_cnt, wrap, done);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nchk++;
      if ({gnt, busy, gray_cnt, wrap, done} !== 18'd0) begin
        nerr++;
        $display("FAIL idle_%0d: gnt=%b busy=%b gray=%h wrap=%b want all 0",
                 i, gnt, busy, gray_cnt, wrap);
      end
    end
  endtask

  task automatic test_single();
    logic [7:0] gexp [3];
    logic [3:0] dexp [3];
    gexp = '{8'h00, 8'h01, 8'h03};
    dexp = '{4'b0000, 4'b0000, 4'b0010};
    req = 4'b0010;
    len = 16'h0030;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req = '0;
      nchk++;
      if (gnt !== 4'b0010 || busy !== 1'b1 || gray_cnt !== gexp[i] ||
          done !== dexp[i]) begin
        nerr++;
        $display("FAIL single_c%0d: gnt=%b busy=%b gray=%h done=%b want 0010 1 %h %b",
                 i, gnt, busy, gray_cnt, done, gexp[i], dexp[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      nchk++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || gray_cnt !== 8'h02 ||
          done !== 4'b0000) begin
        nerr++;
        $display("FAIL single_end%0d: gnt=%b busy=%b gray=%h want 0000 0 02",
                 i, gnt, busy, gray_cnt);
      end
    end
    // ptr is now 2: of requesters 1 and 2, requester 2 must win
    req = 4'b0110;
    len = 16'h0100;
    @(negedge clk);
    req = '0;
    nchk++;
    if (gnt !== 4'b0100 || done !== 4'b0100) begin
      nerr++;
      $display("FAIL single_ptr: gnt=%b done=%b want 0100 0100", gnt, done);
    end
    @(negedge clk);
    nchk++;
    if (gnt !== 4'b0000 || gray_cnt !== 8'h06) begin
      nerr++;
      $display("FAIL single_ptr_step: gnt=%b gray=%h want 0000 06", gnt, gray_cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] ord [5];
    logic [7:0] gexp [5];
    ord  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    gexp = '{8'h01, 8'h03, 8'h02, 8'h06, 8'h07};
    do_reset();
    req = 4'b1111;
    len = 16'h1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 4) req = '0;
      nchk++;
      if (gnt !== ord[k] || done !== ord[k]) begin
        nerr++;
        $display("FAIL rr_grant%0d: gnt=%b done=%b want %b", k, gnt, done, ord[k]);
      end
      @(negedge clk);
      nchk++;
      if (gnt !== 4'b0000 || gray_cnt !== gexp[k]) begin
        nerr++;
        $display("FAIL rr_idle%0d: gnt=%b gray=%h want 0000 %h",
                 k, gnt, gray_cnt, gexp[k]);
      end
    end
  endtask

  task automatic test_zero_len_and_ignored();
    logic [7:0] gexp [4];
    gexp = '{8'h04, 8'h0C, 8'h0D, 8'h0F};
    req = 4'b0100;
    len = 16'h0000;
    @(negedge clk);
    req = '0;
    nchk++;
    if (gnt !== 4'b0100 || done !== 4'b0100) begin
      nerr++;
      $display("FAIL zero_len_gnt: gnt=%b done=%b want 0100 0100", gnt, done);
    end
    @(negedge clk);
    nchk++;
    if (gnt !== 4'b0000 || gray_cnt !== 8'h05) begin
      nerr++;
      $display("FAIL zero_len_step: gnt=%b gray=%h want 0000 05", gnt, gray_cnt);
    end
    req = 4'b0001;
    len = 16'h0005;
    @(negedge clk);
    nchk++;
    if (gnt !== 4'b0001 || gray_cnt !== 8'h05) begin
      nerr++;
      $display("FAIL len5_gnt: gnt=%b gray=%h want 0001 05", gnt, gray_cnt);
    end
    req = 4'b1000;
    len = 16'h1002;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nchk++;
      if (gnt !== 4'b0001 || gray_cnt !== gexp[i] ||
          done !== ((i == 3) ? 4'b0001 : 4'b0000)) begin
        nerr++;
        $display("FAIL len5_c%0d: gnt=%b gray=%h done=%b want 0001 %h",
                 i, gnt, gray_cnt, done, gexp[i]);
      end
    end
    @(negedge clk);
    nchk++;
    if (gnt !== 4'b0000 || gray_cnt !== 8'h0E) begin
      nerr++;
      $display("FAIL len5_end: gnt=%b gray=%h want 0000 0e", gnt, gray_cnt);
    end
    @(negedge clk);
    req = '0;
    nchk++;
    if (gnt !== 4'b1000 || done !== 4'b1000) begin
      nerr++;
      $display("FAIL next_req3: gnt=%b done=%b want 1000 1000", gnt, done);
    end
    @(negedge clk);
    nchk++;
    if (gnt !== 4'b0000 || gray_cnt !== 8'h0A) begin
      nerr++;
      $display("FAIL req3_step: gnt=%b gray=%h want 0000 0a", gnt, gray_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] mbin;
    logic [3:0] mrem;
    logic       mrun;
    logic       mwrap;
    logic [7:0] prev;
    int         nwrap;
    int         bad;
    do_reset();
    req   = 4'b0001;
    len   = 16'hFFFF;
    mbin  = '0;
    mrem  = '0;
    mrun  = 1'b0;
    prev  = 8'h00;
    nwrap = 0;
    bad   = 0;
    for (int c = 0; c < 290; c++) begin
      @(negedge clk);
      mwrap = 1'b0;
      if (!mrun) begin
        mrun = 1'b1;
        mrem = 4'd15;
      end else begin
        mbin  = mbin + 8'd1;
        mwrap = (mbin == 8'd0);
        mrem  = mrem - 4'd1;
        if (mrem == 4'd0) mrun = 1'b0;
      end
      nchk++;
      if (gnt !== (mrun ? 4'b0001 : 4'b0000) || gray_cnt !== g(mbin) ||
          wrap !== mwrap) begin
        nerr++;
        if (bad < 5)
          $display("FAIL wrap_c%0d: gnt=%b gray=%h wrap=%b want %b %h %b",
                   c, gnt, gray_cnt, wrap, mrun ? 4'b0001 : 4'b0000,
                   g(mbin), mwrap);
        bad++;
      end
      if (gray_cnt !== prev) begin
        nchk++;
        if ($countones(gray_cnt ^ prev) != 1) begin
          nerr++;
          $display("FAIL gray_onebit_c%0d: %h -> %h", c, prev, gray_cnt);
        end
      end
      if (wrap === 1'b1) begin
        nwrap++;
        nchk++;
        if (prev !== 8'h80 || gray_cnt !== 8'h00) begin
          nerr++;
          $display("FAIL wrap_from: %h -> %h want 80 -> 00", prev, gray_cnt);
        end
      end
      prev = gray_cnt;
    end
    nchk++;
    if (nwrap != 1) begin
      nerr++;
      $display("FAIL wrap_count: got %0d want 1", nwrap);
    end
    req = '0;
    for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
    nchk++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL wrap_drain: busy=%b want 0 within 20 cycles", busy);
    end
  endtask

  task automatic test_reset_mid_burst();
    req = 4'b0100;
    len = 16'h0800;
    @(negedge clk);
    @(negedge clk);
    nchk++;
    if (gnt !== 4'b0100 || gray_cnt === 8'h00) begin
      nerr++;
      $display("FAIL mid_pre: gnt=%b gray=%h want 0100 nonzero", gnt, gray_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({gnt, busy, gray_cnt, wrap, done} !== 18'd0) begin
      nerr++;
      $display("FAIL mid_abort: gnt=%b busy=%b gray=%h wrap=%b done=%b want 0",
               gnt, busy, gray_cnt, wrap, done);
    end
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // ptr back at 0 selects requester 1 over 3
    req = 4'b1010;
    len = 16'h1010;
    @(negedge clk);
    req = '0;
    nchk++;
    if (gnt !== 4'b0010 || gray_cnt !== 8'h00) begin
      nerr++;
      $display("FAIL mid_regrant: gnt=%b gray=%h want 0010 00", gnt, gray_cnt);
    end
    @(negedge clk);
    nchk++;
    if (gnt !== 4'b0000 || gray_cnt !== 8'h01) begin
      nerr++;
      $display("FAIL mid_step: gnt=%b gray=%h want 0000 01", gnt, gray_cnt);
    end
  endtask

  initial begin
    nchk  = 0;
    nerr  = 0;
    rst_n = 1'b0;
    req   = '0;
    len   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len_and_ignored();
    test_wrap();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
